ddr3_dev_responder: RTL and testbench



---
 rtl/ddr3_resp_pkg.sv | 59 +++++
 rtl/ddr3_dev_responder_bank_tracker.sv | 62 ++++++
 rtl/ddr3_dev_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_ddr3_dev_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_resp_pkg
// Description : Shared types and the command decoder for the DDR3 device-side
//               responder (command, error-code and column-FSM encodings).
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_resp_pkg;

    localparam int NUM_BANKS = 8;
    localparam int BANK_BITS = 3;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5,
        MRS = 3'd6
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ACT_OPEN = 3'd1,
        ERR_REF_OPEN = 3'd2,
        ERR_COL_IDLE = 3'd3,
        ERR_COL_BUSY = 3'd4
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_BURST = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_WR_BURST = 3'd4
    } state_e;

    // Chip-select gates everything; unknown pin combinations read as NOP.
    function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic we_n);
        cmd_e c;
        c = NOP;
        if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  c = ACT;
                3'b101:  c = RD;
                3'b100:  c = WR;
                3'b010:  c = PRE;
                3'b001:  c = REF;
                3'b000:  c = MRS;
                default: c = NOP;
            endcase
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_dev_responder_bank_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_bank_tracker
// Description : Per-bank open/closed state and open-row storage. Opens banks
//               on ACT, closes on PRE / PRE-all / auto-precharge, and flags an
//               ACT aimed at a bank that is already open.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_bank_tracker
    import ddr3_resp_pkg::*;
#(
    parameter int ROW_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 act,
    input  logic                 pre,
    input  logic                 pre_all,
    input  logic [BANK_BITS-1:0] cmd_ba,
    input  logic [ROW_BITS-1:0]  act_row,
    input  logic                 ap_close,
    input  logic [BANK_BITS-1:0] ap_ba,
    output logic                 q_active,
    output logic [ROW_BITS-1:0]  q_row,
    output logic                 any_active,
    output logic                 act_err
);

    logic [NUM_BANKS-1:0] r_active;
    logic [ROW_BITS-1:0]  r_row [NUM_BANKS];

    assign q_active   = r_active[cmd_ba];
    assign q_row      = r_row[cmd_ba];
    assign any_active = |r_active;
    assign act_err    = act && r_active[cmd_ba];

    // Bank open/close bits; an ACT to an open bank leaves the table untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if ((pre && (pre_all || cmd_ba == BANK_BITS'(b))) ||
                    (ap_close && ap_ba == BANK_BITS'(b))) begin
                    r_active[b] <= 1'b0;
                end
                if (act && !r_active[b] && cmd_ba == BANK_BITS'(b)) begin
                    r_active[b] <= 1'b1;
                end
            end
        end
    end

    // Row captured only when the bank actually opens; stale rows are harmless.
    always_ff @(posedge clk) begin
        if (!rst && act && !r_active[cmd_ba]) begin
            r_row[cmd_ba] <= act_row;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_dev_responder.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_dev_responder
// Description : Single-rate DDR3 device model. Decodes commands, tracks banks,
//               returns read bursts after CL, captures write bursts after CWL
//               and records the first protocol violation.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_dev_responder
    import ddr3_resp_pkg::*;
#(
    parameter int CL       = 6,
    parameter int CWL      = 5,
    parameter int BL       = 8,
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 6
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        ddr3_reset_n,
    input  logic        ddr3_cke,
    input  logic        ddr3_cs_n,
    input  logic        ddr3_ras_n,
    input  logic        ddr3_cas_n,
    input  logic        ddr3_we_n,
    input  logic [2:0]  ddr3_ba,
    input  logic [13:0] ddr3_addr,
    input  logic [1:0]  ddr3_dm,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe,
    output logic        dqs_oe,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam int LAT_MAX   = (CL > CWL) ? CL : CWL;
    localparam int LAT_W     = $clog2(LAT_MAX + 1);
    localparam int BEAT_W    = $clog2(BL + 1);
    localparam int MEM_AW    = BANK_BITS + ROW_BITS + COL_BITS;
    localparam int MEM_WORDS = 1 << MEM_AW;

    logic                 w_rst;
    cmd_e                 w_cmd;
    logic                 w_q_active;
    logic [ROW_BITS-1:0]  w_q_row;
    logic                 w_any_active;
    logic                 w_act_err;
    logic                 w_is_col;
    logic                 w_err_hit;
    err_e                 w_err_code;
    logic [2:0]           w_beat_idx;
    logic [2:0]           w_col_lo;
    logic [COL_BITS-1:0]  w_col_i;
    logic [MEM_AW-1:0]    w_mem_addr;
    logic [15:0]          w_mem_rdata;
    logic                 w_wr_fire;
    logic                 w_last_launch;
    logic                 w_ap_close;
    logic                 w_unused_addr;

    state_e               r_state;
    logic [LAT_W-1:0]     r_lat;
    logic [BEAT_W-1:0]    r_beat;
    logic [BANK_BITS-1:0] r_ba;
    logic [ROW_BITS-1:0]  r_row;
    logic [COL_BITS-1:0]  r_col;
    logic                 r_ap;
    logic [15:0]          r_mem [MEM_WORDS];

    assign w_rst         = areset | ~ddr3_reset_n;
    assign w_cmd         = ddr3_cke ? decode_cmd(ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n)
                                    : NOP;
    assign w_is_col      = (w_cmd == RD) || (w_cmd == WR);
    assign w_unused_addr = ^ddr3_addr;

    // Sequential burst order: the low three column bits wrap inside the block.
    assign w_beat_idx  = (r_state == ST_RD_BURST || r_state == ST_WR_BURST) ? 3'(r_beat) : 3'd0;
    assign w_col_lo    = r_col[2:0] + w_beat_idx;
    assign w_col_i     = (r_col & ~COL_BITS'(7)) | COL_BITS'(w_col_lo);
    assign w_mem_addr  = {r_ba, r_row, w_col_i};
    assign w_mem_rdata = r_mem[w_mem_addr];

    assign w_wr_fire = (r_state == ST_WR_WAIT && r_lat == '0) || (r_state == ST_WR_BURST);

    // The edge that launches (read) or captures (write) the final beat.
    assign w_last_launch =
        (r_state == ST_RD_BURST && r_beat == BEAT_W'(BL - 1)) ||
        (r_state == ST_RD_WAIT  && r_lat == '0 && BL == 1)    ||
        (r_state == ST_WR_BURST && r_beat == BEAT_W'(BL - 1)) ||
        (r_state == ST_WR_WAIT  && r_lat == '0 && BL == 1);
    assign w_ap_close = r_ap && w_last_launch;

    ddr3_bank_tracker #(
        .ROW_BITS (ROW_BITS)
    ) u_bank_tracker (
        .clk        (aclk),
        .rst        (w_rst),
        .act        (w_cmd == ACT),
        .pre        (w_cmd == PRE),
        .pre_all    (ddr3_addr[10]),
        .cmd_ba     (ddr3_ba),
        .act_row    (ddr3_addr[ROW_BITS-1:0]),
        .ap_close   (w_ap_close),
        .ap_ba      (r_ba),
        .q_active   (w_q_active),
        .q_row      (w_q_row),
        .any_active (w_any_active),
        .act_err    (w_act_err)
    );

    // Classify the current command's protocol violation, if any.
    always_comb begin
        w_err_hit  = 1'b0;
        w_err_code = ERR_NONE;
        if (w_act_err) begin
            w_err_hit  = 1'b1;
            w_err_code = ERR_ACT_OPEN;
        end else if (w_cmd == REF && w_any_active) begin
            w_err_hit  = 1'b1;
            w_err_code = ERR_REF_OPEN;
        end else if (w_is_col && !w_q_active) begin
            w_err_hit  = 1'b1;
            w_err_code = ERR_COL_IDLE;
        end else if (w_is_col && r_state != ST_IDLE) begin
            w_err_hit  = 1'b1;
            w_err_code = ERR_COL_BUSY;
        end
    end

    // Column FSM with latency/beat counters, registered DQ outputs and error flags.
    always_ff @(posedge aclk) begin
        if (w_rst) begin
            r_state  <= ST_IDLE;
            busy     <= 1'b0;
            dq_o     <= '0;
            dq_oe    <= 1'b0;
            dqs_oe   <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            r_lat    <= '0;
            r_beat   <= '0;
            r_ba     <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_ap     <= 1'b0;
        end else begin
            if (w_err_hit && !err) begin
                err      <= 1'b1;
                err_code <= w_err_code;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_is_col && w_q_active) begin
                        r_state <= (w_cmd == RD) ? ST_RD_WAIT : ST_WR_WAIT;
                        busy    <= 1'b1;
                        r_lat   <= (w_cmd == RD) ? LAT_W'(CL - 1) : LAT_W'(CWL - 1);
                        dqs_oe  <= (w_cmd == RD) && (CL == 1);
                        r_ba    <= ddr3_ba;
                        r_row   <= w_q_row;
                        r_col   <= ddr3_addr[COL_BITS-1:0];
                        r_ap    <= ddr3_addr[10];
                    end
                end
                ST_RD_WAIT: begin
                    if (r_lat == '0) begin
                        r_state <= ST_RD_BURST;
                        dq_oe   <= 1'b1;
                        dqs_oe  <= 1'b1;
                        dq_o    <= w_mem_rdata;
                        r_beat  <= BEAT_W'(1);
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                        if (r_lat == LAT_W'(1)) begin
                            dqs_oe <= 1'b1;
                        end
                    end
                end
                ST_RD_BURST: begin
                    if (r_beat == BEAT_W'(BL)) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                        dq_oe   <= 1'b0;
                        dqs_oe  <= 1'b0;
                        dq_o    <= '0;
                    end else begin
                        dq_o   <= w_mem_rdata;
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                ST_WR_WAIT: begin
                    if (r_lat == '0) begin
                        r_state <= (BL == 1) ? ST_IDLE : ST_WR_BURST;
                        busy    <= (BL != 1);
                        r_beat  <= BEAT_W'(1);
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                ST_WR_BURST: begin
                    if (r_beat == BEAT_W'(BL - 1)) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Byte-masked array write; the array survives reset on purpose.
    always_ff @(posedge aclk) begin
        if (!w_rst && w_wr_fire) begin
            if (!ddr3_dm[0]) r_mem[w_mem_addr][7:0]  <= dq_i[7:0];
            if (!ddr3_dm[1]) r_mem[w_mem_addr][15:8] <= dq_i[15:8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_dev_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_dev_responder
// Description : Directed, table-driven bench for the DDR3 device responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_dev_responder;

    localparam int CL  = 6;
    localparam int CWL = 5;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_REF = 3'b001;

    logic        aclk = 1'b0;
    logic        areset, ddr3_reset_n, cke, cs_n, ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic [1:0]  dm;
    logic [15:0] tb_dq;
    logic        tb_drv;
    logic [15:0] dq_o;
    logic        dq_oe, dqs_oe, err, busy;
    logic [2:0]  err_code;
    wire  [15:0] ddr3_dq_w;

    // Shared DQ wire: device drives when dq_oe, bench drives write data otherwise.
    assign ddr3_dq_w = dq_oe ? dq_o : (tb_drv ? tb_dq : 16'h0000);

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0]        vba;
        logic [5:0]        wcol;
        logic [5:0]        rcol;
        logic [1:0]        dm0;
        logic [7:0][15:0]  wd;
        logic [7:0][15:0]  exp;
    } vec_t;
    vec_t vecs [5];

    ddr3_dev_responder dut (
        .aclk         (aclk),
        .areset       (areset),
        .ddr3_reset_n (ddr3_reset_n),
        .ddr3_cke     (cke),
        .ddr3_cs_n    (cs_n),
        .ddr3_ras_n   (ras_n),
        .ddr3_cas_n   (cas_n),
        .ddr3_we_n    (we_n),
        .ddr3_ba      (ba),
        .ddr3_addr    (addr),
        .ddr3_dm      (dm),
        .dq_i         (ddr3_dq_w),
        .dq_o         (dq_o),
        .dq_oe        (dq_oe),
        .dqs_oe       (dqs_oe),
        .err          (err),
        .err_code     (err_code),
        .busy         (busy)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One command cycle, then back to NOP.
    task automatic cmd(input logic [2:0] rcw, input logic [2:0] b, input logic [13:0] a);
        cs_n = 1'b0; {ras_n, cas_n, we_n} = rcw; ba = b; addr = a;
        tick();
        cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
    endtask

    task automatic do_reset(input bit use_pin);
        if (use_pin) ddr3_reset_n = 1'b0; else areset = 1'b1;
        tick(); tick();
        ddr3_reset_n = 1'b1; areset = 1'b0;
    endtask

    task automatic wr_burst(input logic [2:0] b, input logic [5:0] col,
                            input logic [7:0][15:0] wd, input logic [1:0] dm0);
        cmd(C_WR, b, {8'h00, col});
        repeat (CWL - 1) tick();
        for (int i = 0; i < 8; i++) begin
            tb_drv = 1'b1; tb_dq = wd[i]; dm = (i == 0) ? dm0 : 2'b00;
            tick();
        end
        tb_drv = 1'b0; dm = 2'b00;
    endtask

    // Read burst with strobe/data timing checks; optionally holds cke low with a
    // bogus RD on the pins for the whole burst.
    task automatic rd_burst(input logic [2:0] b, input logic [5:0] col,
                            input logic [7:0][15:0] exp, input string tag, input bit cke_drop);
        cmd(C_RD, b, {8'h00, col});
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        if (cke_drop) begin
            cke = 1'b0; cs_n = 1'b0; {ras_n, cas_n, we_n} = C_RD; ba = 3'd4;
        end
        repeat (CL - 2) tick();
        check({tag, "_dqs_early"}, {31'd0, dqs_oe}, 32'd0);
        tick();
        check({tag, "_dqs_pre"}, {31'd0, dqs_oe}, 32'd1);
        check({tag, "_dq_oe_pre"}, {31'd0, dq_oe}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("%s_oe%0d", tag, i), {31'd0, dq_oe}, 32'd1);
            check($sformatf("%s_beat%0d", tag, i), {16'd0, ddr3_dq_w}, {16'd0, exp[i]});
        end
        tick();
        check({tag, "_oe_end"}, {30'd0, dq_oe, dqs_oe}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
    endtask

    initial begin
        logic [7:0][15:0] v0_exp;
        bit saw_oe;

        vecs[0] = '{3'd2, 6'h10, 6'h10, 2'b00,
                    {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
                    {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        vecs[1] = '{3'd2, 6'h0D, 6'h08, 2'b00,
                    {16'hA007, 16'hA006, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000},
                    {16'hA002, 16'hA001, 16'hA000, 16'hA007, 16'hA006, 16'hA005, 16'hA004, 16'hA003}};
        vecs[2] = '{3'd2, 6'h20, 6'h20, 2'b00,
                    {16'hB007, 16'hB006, 16'hB005, 16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hABCD},
                    {16'hB007, 16'hB006, 16'hB005, 16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hABCD}};
        vecs[3] = '{3'd2, 6'h20, 6'h20, 2'b10,
                    {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'h1234},
                    {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hAB34}};
        vecs[4] = '{3'd7, 6'h3F, 6'h3A, 2'b00,
                    {16'h7007, 16'h7006, 16'h7005, 16'h7004, 16'h7003, 16'h7002, 16'h7001, 16'h7000},
                    {16'h7002, 16'h7001, 16'h7000, 16'h7007, 16'h7006, 16'h7005, 16'h7004, 16'h7003}};
        v0_exp = vecs[0].exp;

        areset = 1'b1; ddr3_reset_n = 1'b1; cke = 1'b1; cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111; ba = '0; addr = '0; dm = '0;
        tb_dq = '0; tb_drv = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        check("reset_outputs", {dq_oe, dqs_oe, err, busy, err_code}, 32'd0);
        check("reset_dq_o", {16'd0, dq_o}, 32'd0);

        // Table: write then read back each vector.
        cmd(C_ACT, 3'd2, 14'd5);
        cmd(C_ACT, 3'd7, 14'd3);
        for (int v = 0; v < 5; v++) begin
            wr_burst(vecs[v].vba, vecs[v].wcol, vecs[v].wd, vecs[v].dm0);
            rd_burst(vecs[v].vba, vecs[v].rcol, vecs[v].exp, $sformatf("vec%0d", v), 1'b0);
            check($sformatf("vec%0d_no_err", v), {28'd0, err, err_code}, 32'd0);
        end

        // RD to idle bank 3, then double ACT: first error code must stick.
        cmd(C_RD, 3'd3, 14'h010);
        check("rd_idle_err", {28'd0, err, err_code}, {28'd0, 1'b1, 3'd3});
        check("rd_idle_busy", {31'd0, busy}, 32'd0);
        saw_oe = 1'b0;
        repeat (CL + 8) begin
            tick();
            if (dq_oe || dqs_oe) saw_oe = 1'b1;
        end
        check("rd_idle_no_oe", {31'd0, saw_oe}, 32'd0);
        cmd(C_ACT, 3'd3, 14'd0);
        cmd(C_ACT, 3'd3, 14'd1);
        check("err_code_sticky", {28'd0, err, err_code}, {28'd0, 1'b1, 3'd3});

        // Auto-precharge read, ACT on the last beat collides.
        do_reset(1'b1);
        check("pin_reset_err", {28'd0, err, err_code}, 32'd0);
        cmd(C_ACT, 3'd2, 14'd5);
        cmd(C_RD, 3'd2, 14'h410);
        repeat (CL + 6) tick();
        cmd(C_ACT, 3'd2, 14'd5);
        check("ap_act_last_beat", {28'd0, err, err_code}, {28'd0, 1'b1, 3'd1});
        tick();

        // Same ACT one cycle later is legal and reopens the row.
        do_reset(1'b0);
        cmd(C_ACT, 3'd2, 14'd5);
        cmd(C_RD, 3'd2, 14'h410);
        repeat (CL + 7) tick();
        cmd(C_ACT, 3'd2, 14'd5);
        check("ap_act_after", {28'd0, err, err_code}, 32'd0);
        rd_burst(3'd2, 6'h10, v0_exp, "ap_reopen", 1'b0);
        check("ap_reopen_no_err", {28'd0, err, err_code}, 32'd0);

        // Reset in the middle of a read burst.
        do_reset(1'b0);
        cmd(C_ACT, 3'd2, 14'd5);
        cmd(C_RD, 3'd2, 14'h010);
        repeat (CL + 3) tick();
        check("mid_beat3", {16'd0, ddr3_dq_w}, 32'h4444);
        areset = 1'b1;
        tick();
        check("mid_reset_idle", {29'd0, dq_oe, dqs_oe, busy}, 32'd0);
        areset = 1'b0;
        cmd(C_RD, 3'd2, 14'h010);
        check("mid_reset_bank_idle", {28'd0, err, err_code}, {28'd0, 1'b1, 3'd3});
        tick();
        check("mid_reset_no_busy", {30'd0, busy, dq_oe}, 32'd0);
        do_reset(1'b0);
        cmd(C_ACT, 3'd2, 14'd5);
        rd_burst(3'd2, 6'h10, v0_exp, "persist_cke", 1'b1);
        check("cke_blocked_no_err", {28'd0, err, err_code}, 32'd0);

        // REF legality, then RD while busy.
        do_reset(1'b0);
        cmd(C_REF, 3'd0, 14'd0);
        check("ref_idle_ok", {28'd0, err, err_code}, 32'd0);
        cmd(C_ACT, 3'd1, 14'd2);
        cmd(C_REF, 3'd0, 14'd0);
        check("ref_active_err", {28'd0, err, err_code}, {28'd0, 1'b1, 3'd2});
        do_reset(1'b0);
        cmd(C_ACT, 3'd2, 14'd5);
        cmd(C_RD, 3'd2, 14'h010);
        cmd(C_RD, 3'd2, 14'h010);
        check("rd_busy_err", {28'd0, err, err_code}, {28'd0, 1'b1, 3'd4});
        repeat (CL - 1) tick();
        check("rd_busy_burst_oe", {31'd0, dq_oe}, 32'd1);
        check("rd_busy_burst_d0", {16'd0, ddr3_dq_w}, 32'h1111);
        repeat (8) tick();
        check("rd_busy_burst_done", {30'd0, busy, dq_oe}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
